// File: rtl/obstacle_scheduler_if.sv
// Purpose : handshake/status bundle between the obstacle scheduler and game/VGA logic.
// Latency : n/a (wiring only); every scheduler output is a registered signal.
// Backpr. : drawer requests are level-held until a single-cycle draw_done acknowledge.
//
// Ports (slave = scheduler side):
//   in : enable, collision, ld_shape, draw_done
//   out: erase_req, draw_req, update, speed[1:0], score[7:0], game_over, overrun
interface obstacle_scheduler_if;
    logic       enable;
    logic       collision;
    logic       ld_shape;
    logic       draw_done;
    logic       erase_req;
    logic       draw_req;
    logic       update;
    logic [1:0] speed;
    logic [7:0] score;
    logic       game_over;
    logic       overrun;

    modport master (
        output enable, collision, ld_shape, draw_done,
        input  erase_req, draw_req, update, speed, score, game_over, overrun
    );

    modport slave (
        input  enable, collision, ld_shape, draw_done,
        output erase_req, draw_req, update, speed, score, game_over, overrun
    );
endinterface

// File: rtl/obstacle_scheduler.sv
// Purpose : frame-rate sequencer running erase -> advance -> redraw once per game step.
// Latency : step tick to erase_req 1 cycle; draw_done to update 1 cycle, to draw_req 2 cycles.
// Backpr. : erase/draw requests hold until draw_done; step ticks arriving while busy are dropped (overrun).
//
// Ports: clk, resetn (async active-low); bus = obstacle_scheduler_if.slave
//   (enable, collision, ld_shape, draw_done in; erase_req, draw_req, update,
//    speed, score, game_over, overrun out -- all outputs registered).
module obstacle_scheduler #(
    parameter int FRAME_DIV       = 833334,
    parameter int FRAMES_PER_STEP = 2,
    parameter int LEVEL_UP        = 8
) (
    input logic               clk,
    input logic               resetn,
    obstacle_scheduler_if.slave bus
);

    localparam int FW = $clog2(FRAME_DIV);
    localparam int SW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam int WW = (LEVEL_UP > 1) ? $clog2(LEVEL_UP) : 1;

    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_DIV - 1);
    localparam logic [SW-1:0] STEP_LAST  = SW'(FRAMES_PER_STEP - 1);
    localparam logic [WW-1:0] WRAP_LAST  = WW'(LEVEL_UP - 1);

    typedef enum logic [2:0] {S_WAIT, S_ERASE, S_ADV, S_DRAW, S_OVER} state_t;

    state_t        state_q, state_d;
    logic [FW-1:0] frame_cnt_q, frame_cnt_d;
    logic [SW-1:0] step_cnt_q, step_cnt_d;
    logic [WW-1:0] wrap_cnt_q, wrap_cnt_d;
    logic          pending_q, pending_d;
    logic [7:0]    score_q, score_d;
    logic [1:0]    speed_q, speed_d;
    logic          game_over_q, game_over_d;
    logic          overrun_q, overrun_d;
    logic          erase_req_q, erase_req_d;
    logic          draw_req_q, draw_req_d;
    logic          update_q, update_d;
    logic          frame_tick, step_tick;

    always_comb begin
        frame_tick  = bus.enable && (frame_cnt_q == FRAME_LAST);
        step_tick   = frame_tick && (step_cnt_q == STEP_LAST);

        frame_cnt_d = frame_cnt_q;
        step_cnt_d  = step_cnt_q;
        state_d     = state_q;
        pending_d   = pending_q;
        score_d     = score_q;
        speed_d     = speed_q;
        wrap_cnt_d  = wrap_cnt_q;
        overrun_d   = overrun_q;

        // Counters freeze while paused; they keep running even when the FSM is busy.
        if (bus.enable) begin
            frame_cnt_d = frame_tick ? '0 : frame_cnt_q + 1'b1;
        end
        if (frame_tick) begin
            step_cnt_d = step_tick ? '0 : step_cnt_q + 1'b1;
        end

        if (step_tick && (state_q != S_WAIT)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            S_WAIT: begin
                // A collision (live or deferred from the last step) beats a step tick.
                if (bus.collision || pending_q) begin
                    state_d   = S_OVER;
                    pending_d = 1'b0;
                end else if (step_tick) begin
                    state_d = S_ERASE;
                end
            end
            S_ERASE: begin
                if (bus.collision) pending_d = 1'b1;
                if (bus.draw_done) state_d = S_ADV;
            end
            S_ADV: begin
                if (bus.collision) pending_d = 1'b1;
                if (bus.ld_shape) begin
                    if (score_q != 8'hFF) score_d = score_q + 8'd1;
                    if (wrap_cnt_q == WRAP_LAST) begin
                        wrap_cnt_d = '0;
                        if (speed_q != 2'd3) speed_d = speed_q + 2'd1;
                    end else begin
                        wrap_cnt_d = wrap_cnt_q + 1'b1;
                    end
                end
                state_d = S_DRAW;
            end
            S_DRAW: begin
                if (bus.collision) pending_d = 1'b1;
                if (bus.draw_done) state_d = S_WAIT;
            end
            S_OVER:  state_d = S_OVER;
            default: state_d = S_WAIT;
        endcase

        // Outputs are decoded from the next state so they are registered alongside it.
        game_over_d = game_over_q || (state_d == S_OVER);
        erase_req_d = (state_d == S_ERASE);
        draw_req_d  = (state_d == S_DRAW);
        update_d    = (state_d == S_ADV);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_WAIT;
            frame_cnt_q <= '0;
            step_cnt_q  <= '0;
            wrap_cnt_q  <= '0;
            pending_q   <= 1'b0;
            score_q     <= '0;
            speed_q     <= '0;
            game_over_q <= 1'b0;
            overrun_q   <= 1'b0;
            erase_req_q <= 1'b0;
            draw_req_q  <= 1'b0;
            update_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            step_cnt_q  <= step_cnt_d;
            wrap_cnt_q  <= wrap_cnt_d;
            pending_q   <= pending_d;
            score_q     <= score_d;
            speed_q     <= speed_d;
            game_over_q <= game_over_d;
            overrun_q   <= overrun_d;
            erase_req_q <= erase_req_d;
            draw_req_q  <= draw_req_d;
            update_q    <= update_d;
        end
    end

    assign bus.erase_req = erase_req_q;
    assign bus.draw_req  = draw_req_q;
    assign bus.update    = update_q;
    assign bus.speed     = speed_q;
    assign bus.score     = score_q;
    assign bus.game_over = game_over_q;
    assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Purpose : self-checking bench for obstacle_scheduler (FRAME_DIV=4, FRAMES_PER_STEP=2, LEVEL_UP=2,
//           plus a FRAME_DIV=2 / FRAMES_PER_STEP=1 / LEVEL_UP=1 instance for score saturation).
// Cycle k = k rising edges after reset release; outputs sampled and inputs driven on the falling edge.
module tb_obstacle_scheduler;

    logic clk;
    logic resetn;
    logic resetn2;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    obstacle_scheduler_if u_if ();
    obstacle_scheduler_if u_if2 ();

    obstacle_scheduler #(.FRAME_DIV(4), .FRAMES_PER_STEP(2), .LEVEL_UP(2)) u_dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (u_if)
    );

    obstacle_scheduler #(.FRAME_DIV(2), .FRAMES_PER_STEP(1), .LEVEL_UP(1)) u_dut2 (
        .clk    (clk),
        .resetn (resetn2),
        .bus    (u_if2)
    );

    typedef struct packed {
        logic       en, col, ld, dd;
        logic       er, dr, up;
        logic [1:0] spd;
        logic [7:0] sc;
        logic       go, ov;
    } vec_t;

    vec_t vec [17];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int upd_cnt = 0;
    int viol = 0;
    bit auto_ack = 1'b0;
    bit prev_upd = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance one cycle; track update pulses and output invariants; optional auto drawer.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (u_if.update === 1'b1) begin
            upd_cnt++;
            if (prev_upd) viol++;
        end
        prev_upd = (u_if.update === 1'b1);
        if (u_if.erase_req === 1'b1 && u_if.draw_req === 1'b1) viol++;
        if (auto_ack) u_if.draw_done = u_if.erase_req | u_if.draw_req;
    endtask

    // sel: 0 = erase_req, 1 = draw_req, other = update
    task automatic wait_for(input int sel, input int max_cyc, input string name);
        int n = 0;
        bit hit = 1'b0;
        while (!hit && n < max_cyc) begin
            tick();
            n++;
            case (sel)
                0:       hit = (u_if.erase_req === 1'b1);
                1:       hit = (u_if.draw_req === 1'b1);
                default: hit = (u_if.update === 1'b1);
            endcase
        end
        if (!hit) begin
            checks++;
            failures++;
            $display("FAIL %s: no event within %0d cycles, expected one", name, max_cyc);
        end
    endtask

    function automatic int spd_exp(input int w);
        return (w / 2 > 3) ? 3 : w / 2;
    endfunction

    logic [14:0] act_v, exp_v;
    int c0, c1, c3, base, up0, seen, n2;
    bit pu, done2;

    initial begin
        resetn = 1'b0;
        resetn2 = 1'b0;
        u_if.enable = 1'b0;  u_if.collision = 1'b0;  u_if.ld_shape = 1'b0;  u_if.draw_done = 1'b0;
        u_if2.enable = 1'b0; u_if2.collision = 1'b0; u_if2.ld_shape = 1'b0; u_if2.draw_done = 1'b0;

        // First step with a drawer that acks erase one cycle late and draw at once;
        // spurious acks in WAIT (2, 13) and ADV (10) must be ignored.
        for (int k = 0; k < 17; k++) vec[k] = '{en: 1'b1, default: '0};
        vec[2].dd  = 1'b1;
        vec[8].er  = 1'b1;
        vec[9].er  = 1'b1;  vec[9].dd  = 1'b1;
        vec[10].up = 1'b1;  vec[10].dd = 1'b1;
        vec[11].dr = 1'b1;  vec[11].dd = 1'b1;
        vec[13].dd = 1'b1;
        vec[16].er = 1'b1;  vec[16].ld = 1'b1;

        repeat (3) @(negedge clk);
        resetn = 1'b1;
        cyc = 0;
        for (int k = 0; k < 17; k++) begin
            if (k > 0) tick();
            act_v = {u_if.erase_req, u_if.draw_req, u_if.update, u_if.speed, u_if.score,
                     u_if.game_over, u_if.overrun};
            exp_v = {vec[k].er, vec[k].dr, vec[k].up, vec[k].spd, vec[k].sc, vec[k].go, vec[k].ov};
            chk($sformatf("vec_cycle%0d", k), int'(act_v), int'(exp_v));
            u_if.enable    = vec[k].en;
            u_if.collision = vec[k].col;
            u_if.ld_shape  = vec[k].ld;
            u_if.draw_done = vec[k].dd;
        end

        // Level up: every step wraps; speed changes only after the update cycle.
        auto_ack = 1'b1;
        for (int w = 1; w <= 10; w++) begin
            wait_for(2, 20, $sformatf("lvl_update%0d", w));
            chk($sformatf("speed_at_update%0d", w), int'(u_if.speed), spd_exp(w - 1));
            tick();
            chk($sformatf("score_after%0d", w), int'(u_if.score), w);
            chk($sformatf("speed_after%0d", w), int'(u_if.speed), spd_exp(w));
        end

        // Pause in WAIT: next erase slips by exactly the paused cycles.
        wait_for(0, 20, "erase_a");
        c0 = cyc;
        wait_for(0, 20, "erase_b");
        chk("step_period", cyc - c0, 8);
        c1 = cyc;
        repeat (4) tick();
        u_if.enable = 1'b0;
        seen = 0;
        repeat (10) begin
            tick();
            if (u_if.erase_req === 1'b1) seen++;
        end
        u_if.enable = 1'b1;
        chk("pause_no_erase", seen, 0);
        wait_for(0, 30, "erase_after_pause");
        chk("pause_delay", cyc - c1, 18);

        // Pause while ERASE is pending: request held, acknowledges still honoured.
        repeat (3) tick();
        auto_ack = 1'b0;
        u_if.draw_done = 1'b0;
        wait_for(0, 20, "erase_c");
        c3 = cyc;
        u_if.enable = 1'b0;
        seen = 0;
        repeat (3) begin
            tick();
            if (u_if.erase_req === 1'b1) seen++;
        end
        chk("erase_held_paused", seen, 3);
        u_if.draw_done = 1'b1;
        tick();
        u_if.draw_done = 1'b0;
        chk("update_paused", int'(u_if.update), 1);
        chk("erase_drop_paused", int'(u_if.erase_req), 0);
        tick();
        chk("draw_req_paused", int'(u_if.draw_req), 1);
        u_if.draw_done = 1'b1;
        tick();
        u_if.draw_done = 1'b0;
        chk("draw_done_paused", int'(u_if.draw_req), 0);
        chk("paused_step_len", cyc - c3, 6);
        u_if.enable = 1'b1;

        // Overrun: withheld acknowledge drops ticks but the step still updates once.
        chk("overrun_clear", int'(u_if.overrun), 0);
        wait_for(0, 20, "erase_d");
        up0 = upd_cnt;
        repeat (20) tick();
        chk("erase_withheld", int'(u_if.erase_req), 1);
        chk("overrun_set", int'(u_if.overrun), 1);
        auto_ack = 1'b1;
        wait_for(1, 10, "draw_d");
        tick();
        chk("overrun_one_update", upd_cnt - up0, 1);

        // Collision during ERASE: step completes, then OVER.
        auto_ack = 1'b0;
        u_if.draw_done = 1'b0;
        wait_for(0, 20, "erase_e");
        up0 = upd_cnt;
        u_if.collision = 1'b1;
        u_if.draw_done = 1'b1;
        tick();
        u_if.collision = 1'b0;
        u_if.draw_done = 1'b0;
        chk("col_update", int'(u_if.update), 1);
        tick();
        chk("col_draw", int'(u_if.draw_req), 1);
        u_if.draw_done = 1'b1;
        tick();
        u_if.draw_done = 1'b0;
        chk("col_not_over_yet", int'(u_if.game_over), 0);
        tick();
        chk("col_game_over", int'(u_if.game_over), 1);
        chk("col_one_update", upd_cnt - up0, 1);
        auto_ack = 1'b1;
        up0 = upd_cnt;
        seen = 0;
        repeat (30) begin
            tick();
            if (u_if.erase_req === 1'b1) seen++;
        end
        chk("over_no_update", upd_cnt - up0, 0);
        chk("over_no_erase", seen, 0);

        // Async reset clears sticky flags.
        resetn = 1'b0;
        #1;
        chk("rst_game_over", int'(u_if.game_over), 0);
        chk("rst_overrun", int'(u_if.overrun), 0);
        tick();
        resetn = 1'b1;
        u_if.ld_shape = 1'b1;
        auto_ack = 1'b1;

        // Async reset mid-DRAW after three wraps.
        wait_for(2, 20, "r_up1");
        wait_for(2, 20, "r_up2");
        wait_for(0, 20, "r_erase3");
        auto_ack = 1'b0;
        tick();
        u_if.draw_done = 1'b0;
        tick();
        chk("pre_rst_draw", int'(u_if.draw_req), 1);
        chk("pre_rst_score", int'(u_if.score), 3);
        chk("pre_rst_speed", int'(u_if.speed), 1);
        #2;
        resetn = 1'b0;
        #1;
        chk("rst_draw_req", int'(u_if.draw_req), 0);
        chk("rst_score", int'(u_if.score), 0);
        chk("rst_speed", int'(u_if.speed), 0);
        chk("rst_update", int'(u_if.update), 0);
        tick();
        resetn = 1'b1;
        u_if.draw_done = 1'b1;
        base = cyc;
        up0 = upd_cnt;
        tick();
        u_if.draw_done = 1'b0;
        wait_for(0, 20, "rst_erase");
        chk("rst_first_erase", cyc - base, 8);
        chk("rst_stale_ack", upd_cnt - up0, 0);

        // Collision in WAIT: OVER next cycle, no further steps.
        u_if.draw_done = 1'b1;
        tick();
        u_if.draw_done = 1'b0;
        tick();
        u_if.draw_done = 1'b1;
        tick();
        u_if.draw_done = 1'b0;
        chk("wait_state_before_col", int'(u_if.draw_req), 0);
        u_if.collision = 1'b1;
        tick();
        u_if.collision = 1'b0;
        chk("wait_col_over", int'(u_if.game_over), 1);
        auto_ack = 1'b1;
        up0 = upd_cnt;
        seen = 0;
        repeat (30) begin
            tick();
            if (u_if.erase_req === 1'b1) seen++;
        end
        chk("wait_col_no_update", upd_cnt - up0, 0);
        chk("wait_col_no_erase", seen, 0);
        chk("invariants", viol, 0);

        // Score saturation on the fast instance.
        @(negedge clk);
        resetn2 = 1'b1;
        u_if2.enable = 1'b1;
        u_if2.ld_shape = 1'b1;
        n2 = 0;
        pu = 1'b0;
        done2 = 1'b0;
        for (int i = 0; i < 4000 && !done2; i++) begin
            @(negedge clk);
            if (pu) begin
                if (n2 == 254) chk("sat_score254", int'(u_if2.score), 254);
                if (n2 == 255) chk("sat_score255", int'(u_if2.score), 255);
                if (n2 == 256) chk("sat_score256", int'(u_if2.score), 255);
                if (n2 == 257) begin
                    chk("sat_score257", int'(u_if2.score), 255);
                    chk("sat_speed", int'(u_if2.speed), 3);
                    done2 = 1'b1;
                end
            end
            pu = (u_if2.update === 1'b1);
            if (pu) n2++;
            u_if2.draw_done = u_if2.erase_req | u_if2.draw_req;
        end
        if (!done2) begin
            checks++;
            failures++;
            $display("FAIL sat_timeout: got %0d updates expected 257", n2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
